custmul_mac_seq: RTL and testbench



---
 rtl/custmul_pkg.sv | 25 ++
 rtl/custmul_valid_dly.sv | 38 +++
 rtl/custmul_mac_seq.sv | 128 ++++++++++++
 tb/tb_custmul_mac_seq.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/custmul_pkg.sv
// -----------------------------------------------------------------------------
// custmul_pkg
// Shared constants and helpers for wrappers around the custmul hard multiplier
// tile.
//   MUL_W          operand / product width of the tile (fixed at 16)
//   ACC_W_DEFAULT  default accumulator width used by the MAC sequencer
//   clog2()        counter width for a modulus of 'value' (minimum 1 bit)
// -----------------------------------------------------------------------------
package custmul_pkg;

  localparam int MUL_W         = 16;
  localparam int ACC_W_DEFAULT = 24;

  // Bits needed to hold 0..value-1. Returns at least 1 so that a
  // modulus of 1 or 2 still yields a legal vector width.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) begin
      width++;
    end
    return width;
  endfunction

endpackage : custmul_pkg

// File: rtl/custmul_valid_dly.sv
// -----------------------------------------------------------------------------
// custmul_valid_dly
// DEPTH-stage valid shift register. Its tap rises exactly DEPTH cycles after
// din, so it marks the cycle in which the custmul tile presents the product of
// the operands issued alongside din.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low clear of every stage
//   din    valid entering the pipeline (operand issue strobe)
//   tap    valid leaving the pipeline (product present on Q)
// -----------------------------------------------------------------------------
module custmul_valid_dly #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic tap
);

  logic [DEPTH-1:0] stages;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    // NOTE: reset lives inside the clocked block, so it is synchronous; this
    // register is small, so clearing it costs nothing and drops in-flight valids.
    if (!rst_n) begin
      stages <= '0;
    end else begin
      // Shift-and-or form works for DEPTH == 1 without a degenerate slice.
      stages <= (stages << 1) | DEPTH'(din);
    end
  end

  assign tap = stages[DEPTH-1];

endmodule : custmul_valid_dly

// File: rtl/custmul_mac_seq.sv
// -----------------------------------------------------------------------------
// custmul_mac_seq
// Streaming operand sequencer and accumulator around the custmul tile.
// Operand pairs accepted over valid/ready are driven straight onto the tile's
// I0/I1 pins; the tile's Q output is realigned with a valid delay line and
// ACC_LEN consecutive products are summed into a valid/ready holding register.
// Ports:
//   clk        clock, shared with the custmul C pin
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair this cycle
//   in_a/in_b  operands (16 bit)
//   mul_i0/1   to custmul I0/I1 (zero when nothing is issued)
//   mul_q      from custmul Q (low 16 bits of the product)
//   out_valid  group sum available
//   out_ready  consumer accepts the sum
//   out_sum    group sum, ACC_W bits
//   out_ovf    group sum wrapped past ACC_W bits
// -----------------------------------------------------------------------------
module custmul_mac_seq
  import custmul_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int ACC_LEN = 4,
  parameter int ACC_W   = ACC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MUL_W-1:0] in_a,
  input  logic [MUL_W-1:0] in_b,
  output logic [MUL_W-1:0] mul_i0,
  output logic [MUL_W-1:0] mul_i1,
  input  logic [MUL_W-1:0] mul_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int              CNT_W = clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACC_LEN - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  // Issue side
  logic             fire;
  logic             out_hs;
  logic [CNT_W-1:0] issue_cnt;
  logic             pending;

  // Accumulate side
  logic             tap;
  logic [CNT_W-1:0] acc_cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf_acc;
  logic [ACC_W:0]   sum_ext;

  assign out_hs = out_valid & out_ready;
  assign fire   = in_valid & in_ready;

  // The last operand of a group may only issue when no earlier completed group
  // is still waiting, or when that group is leaving this very cycle. This caps
  // the backlog at one group, so the output register can never be overrun even
  // though products in flight in the tile cannot be stalled.
  assign in_ready = (issue_cnt != LAST) | ~pending | out_hs;

  // Operands go to the tile combinationally; idle cycles present zero.
  assign mul_i0 = fire ? in_a : '0;
  assign mul_i1 = fire ? in_b : '0;

  custmul_valid_dly #(
    .DEPTH (MUL_LAT)
  ) u_valid_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (fire),
    .tap   (tap)
  );

  // One extra bit captures the carry out of the ACC_W-bit addition.
  assign sum_ext = (ACC_W + 1)'(acc) + (ACC_W + 1)'(mul_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      pending   <= 1'b0;
      acc_cnt   <= '0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (fire) begin
        issue_cnt <= (issue_cnt == LAST) ? '0 : issue_cnt + ONE;
      end

      // A new completed group outranks the release of the previous one.
      if (fire && (issue_cnt == LAST)) begin
        pending <= 1'b1;
      end else if (out_hs) begin
        pending <= 1'b0;
      end

      // Release first; a group completing this cycle overrides it below.
      if (out_hs) begin
        out_valid <= 1'b0;
      end

      if (tap) begin
        if (acc_cnt == LAST) begin
          out_sum   <= sum_ext[ACC_W-1:0];
          out_ovf   <= ovf_acc | sum_ext[ACC_W];
          out_valid <= 1'b1;
          acc       <= '0;
          ovf_acc   <= 1'b0;
          acc_cnt   <= '0;
        end else begin
          acc       <= sum_ext[ACC_W-1:0];
          ovf_acc   <= ovf_acc | sum_ext[ACC_W];
          acc_cnt   <= acc_cnt + ONE;
        end
      end
    end
  end

endmodule : custmul_mac_seq

// File: tb/tb_custmul_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_custmul_mac_seq
// Directed bench for custmul_mac_seq. Two instances share all stimulus: one at
// the default ACC_W=24 and one at ACC_W=17 to expose accumulator wrap. Each
// drives its own behavioural custmul model (Q = low 16 bits of I0*I1, delayed
// MUL_LAT cycles). Output handshakes are logged into per-instance queues and
// each test task compares them against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_custmul_mac_seq;

  localparam int MUL_LAT = 1;
  localparam int ACC_LEN = 4;

  typedef struct {
    logic [23:0] sum;
    logic        ovf;
    int          cyc;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_ready;

  logic        in_ready_w, in_ready_n;
  logic [15:0] mul_i0_w, mul_i1_w, mul_q_w;
  logic [15:0] mul_i0_n, mul_i1_n, mul_q_n;
  logic        out_valid_w, out_valid_n;
  logic [23:0] out_sum_w;
  logic [16:0] out_sum_n;
  logic        out_ovf_w, out_ovf_n;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fire = 0;
  int valid_cnt = 0;
  int stall_cnt = 0;
  res_t q_w[$];
  res_t q_n[$];

  custmul_mac_seq #(.MUL_LAT(MUL_LAT), .ACC_LEN(ACC_LEN), .ACC_W(24)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .mul_i0(mul_i0_w), .mul_i1(mul_i1_w),
    .mul_q(mul_q_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_sum(out_sum_w), .out_ovf(out_ovf_w)
  );

  custmul_mac_seq #(.MUL_LAT(MUL_LAT), .ACC_LEN(ACC_LEN), .ACC_W(17)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_a(in_a), .in_b(in_b), .mul_i0(mul_i0_n), .mul_i1(mul_i1_n),
    .mul_q(mul_q_n), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_sum(out_sum_n), .out_ovf(out_ovf_n)
  );

  // Behavioural custmul tile: no reset, just a product pipeline.
  function automatic logic [15:0] lo16(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = x * y;
    return p[15:0];
  endfunction

  logic [15:0] pipe_w [MUL_LAT];
  logic [15:0] pipe_n [MUL_LAT];
  always @(posedge clk) begin
    pipe_w[0] <= lo16(mul_i0_w, mul_i1_w);
    pipe_n[0] <= lo16(mul_i0_n, mul_i1_n);
    for (int i = 1; i < MUL_LAT; i++) begin
      pipe_w[i] <= pipe_w[i-1];
      pipe_n[i] <= pipe_n[i-1];
    end
  end
  assign mul_q_w = pipe_w[MUL_LAT-1];
  assign mul_q_n = pipe_n[MUL_LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log handshakes, fire times and stalls away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid_w && out_ready) q_w.push_back('{sum: out_sum_w, ovf: out_ovf_w, cyc: cyc});
      if (out_valid_n && out_ready) q_n.push_back('{sum: 24'(out_sum_n), ovf: out_ovf_n, cyc: cyc});
      if (out_valid_w) valid_cnt++;
      if (in_valid && in_ready_w) last_fire = cyc;
      if (in_valid && !in_ready_w) stall_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q_w.delete();
    q_n.delete();
    valid_cnt = 0;
    stall_cnt = 0;
  endtask

  // Present one operand pair and hold it until it is accepted (bounded).
  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    while (!in_ready_w && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (!in_ready_w) begin
      bad++;
      $display("FAIL push_accept: in_ready stuck at %0b, required 1", in_ready_w);
    end
    tick();
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
  endtask

  task automatic wait_res(input int n, input int budget);
    int k;
    k = 0;
    while (q_w.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (q_w.size() < n) begin
      bad++;
      $display("FAIL wait_results: got %0d sums, required %0d", q_w.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    total++;
    if ({out_valid_w, out_sum_w, out_ovf_w} !== 26'd0) begin
      bad++;
      $display("FAIL reset_out_w: got v=%0b s=%h o=%0b, required all 0", out_valid_w, out_sum_w, out_ovf_w);
    end
    total++;
    if ({out_valid_n, out_sum_n, out_ovf_n} !== 19'd0) begin
      bad++;
      $display("FAIL reset_out_n: got v=%0b s=%h o=%0b, required all 0", out_valid_n, out_sum_n, out_ovf_n);
    end
    total++;
    if (in_ready_w !== 1'b1 || mul_i0_w !== 16'h0 || mul_i1_w !== 16'h0) begin
      bad++;
      $display("FAIL reset_issue: got rdy=%0b i0=%h i1=%h, required 1/0/0", in_ready_w, mul_i0_w, mul_i1_w);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_comb_path();
    clear_logs();
    out_ready = 1'b1;
    in_a = 16'h1234;
    in_b = 16'h0002;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mul_i0_w !== 16'h0 || mul_i1_w !== 16'h0) begin
      bad++;
      $display("FAIL mul_idle: got i0=%h i1=%h, required 0000/0000", mul_i0_w, mul_i1_w);
    end
    in_valid = 1'b1;
    #1;
    total++;
    if (mul_i0_w !== 16'h1234 || mul_i1_w !== 16'h0002) begin
      bad++;
      $display("FAIL mul_fire: got i0=%h i1=%h, required 1234/0002", mul_i0_w, mul_i1_w);
    end
    tick();
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (3) push(16'h0, 16'h0);
    wait_res(1, 20);
    repeat (4) tick();
    total++;
    if (q_w.size() != 1 || q_w[0].sum !== 24'h002468) begin
      bad++;
      $display("FAIL comb_group_sum: got n=%0d sum=%h, required 1 x 002468", q_w.size(), (q_w.size() > 0) ? q_w[0].sum : 24'hx);
    end
  endtask

  task automatic test_basic();
    clear_logs();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push(16'(i), 16'd2);
    wait_res(1, 20);
    repeat (5) tick();
    total++;
    if (q_w.size() != 1 || q_w[0].sum !== 24'd20 || q_w[0].ovf !== 1'b0) begin
      bad++;
      $display("FAIL basic_sum: got n=%0d sum=%0d, required 1 x 20 ovf 0", q_w.size(), (q_w.size() > 0) ? q_w[0].sum : 24'hx);
    end
    total++;
    if (q_w.size() < 1 || (q_w[0].cyc - last_fire) != MUL_LAT + 1) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles after last fire, required %0d", (q_w.size() > 0) ? q_w[0].cyc - last_fire : -1, MUL_LAT + 1);
    end
    total++;
    if (valid_cnt != 1) begin
      bad++;
      $display("FAIL basic_valid_width: out_valid high %0d cycles, required 1", valid_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    out_ready = 1'b1;
    repeat (8) push(16'h00FF, 16'h00FF);
    wait_res(2, 30);
    repeat (4) tick();
    total++;
    if (q_w.size() != 2 || q_w[0].sum !== 24'h03F804 || q_w[1].sum !== 24'h03F804 || q_w[0].ovf || q_w[1].ovf) begin
      bad++;
      $display("FAIL b2b_sums_w: got n=%0d, required 2 x 03F804 ovf 0", q_w.size());
    end
    total++;
    if (q_w.size() != 2 || (q_w[1].cyc - q_w[0].cyc) != ACC_LEN) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d sums / spacing wrong, required spacing %0d", q_w.size(), ACC_LEN);
    end
    total++;
    if (stall_cnt != 0) begin
      bad++;
      $display("FAIL b2b_in_ready: in_ready dropped %0d cycles, required 0", stall_cnt);
    end
    total++;
    if (q_n.size() != 2 || q_n[1].sum !== 24'h01F804 || q_n[1].ovf !== 1'b1) begin
      bad++;
      $display("FAIL b2b_sums_n: got n=%0d, required 2nd sum 1F804 ovf 1", q_n.size());
    end
  endtask

  task automatic test_trunc_ovf();
    clear_logs();
    out_ready = 1'b1;
    repeat (4) push(16'h1000, 16'h0010);
    repeat (4) push(16'h00FF, 16'h00FF);
    wait_res(2, 30);
    repeat (4) tick();
    total++;
    if (q_n.size() != 2 || q_n[0].sum !== 24'h0 || q_n[0].ovf !== 1'b0) begin
      bad++;
      $display("FAIL trunc_n: got n=%0d sum=%h, required 00000 ovf 0", q_n.size(), (q_n.size() > 0) ? q_n[0].sum : 24'hx);
    end
    total++;
    if (q_n.size() != 2 || q_n[1].sum !== 24'h01F804 || q_n[1].ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_n: got n=%0d sum=%h ovf=%0b, required 1F804 ovf 1", q_n.size(), (q_n.size() > 1) ? q_n[1].sum : 24'hx, (q_n.size() > 1) ? q_n[1].ovf : 1'bx);
    end
    total++;
    if (q_w.size() != 2 || q_w[0].sum !== 24'h0 || q_w[1].ovf !== 1'b0) begin
      bad++;
      $display("FAIL trunc_w: got n=%0d, required sums 000000/03F804 without ovf", q_w.size());
    end
  endtask

  task automatic test_backpressure();
    int guard;
    clear_logs();
    out_ready = 1'b0;
    repeat (7) push(16'h1, 16'h1);
    in_valid = 1'b1;
    in_a = 16'h1;
    in_b = 16'h1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (in_ready_w !== 1'b0 || out_valid_w !== 1'b1 || out_sum_w !== 24'd4) begin
        bad++;
        $display("FAIL bp_hold: got rdy=%0b v=%0b sum=%0d, required 0/1/4", in_ready_w, out_valid_w, out_sum_w);
      end
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready_w !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: in_ready=%0b on out handshake, required 1", in_ready_w);
    end
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    guard = 0;
    @(negedge clk);
    while (!out_valid_w && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (out_valid_w !== 1'b1 || out_sum_w !== 24'd4) begin
      bad++;
      $display("FAIL bp_second: got v=%0b sum=%0d, required 1/4", out_valid_w, out_sum_w);
    end
    tick();
    out_ready = 1'b1;
    wait_res(2, 10);
    repeat (3) tick();
    total++;
    if (q_w.size() != 2 || q_w[0].sum !== 24'd4 || q_w[1].sum !== 24'd4) begin
      bad++;
      $display("FAIL bp_sums: got n=%0d, required 2 x 4", q_w.size());
    end
  endtask

  task automatic test_gaps();
    clear_logs();
    out_ready = 1'b1;
    push(16'h1, 16'h1);
    repeat (3) tick();
    push(16'h1, 16'h1);
    push(16'h1, 16'h1);
    tick();
    push(16'h1, 16'h1);
    repeat (10) tick();
    total++;
    if (q_w.size() != 1 || q_w[0].sum !== 24'd4) begin
      bad++;
      $display("FAIL gaps_sum: got n=%0d, required single sum 4", q_w.size());
    end
    total++;
    if (valid_cnt != 1) begin
      bad++;
      $display("FAIL gaps_valid: out_valid high %0d cycles, required 1", valid_cnt);
    end
  endtask

  task automatic test_reset_mid_group();
    clear_logs();
    out_ready = 1'b1;
    push(16'h5, 16'h5);
    push(16'h5, 16'h5);
    rst_n = 1'b0;
    tick();
    total++;
    if ({out_valid_w, out_sum_w, out_ovf_w} !== 26'd0 || {out_valid_n, out_sum_n, out_ovf_n} !== 19'd0) begin
      bad++;
      $display("FAIL midrst_out: got sum_w=%h sum_n=%h, required all outputs 0", out_sum_w, out_sum_n);
    end
    total++;
    if (in_ready_w !== 1'b1 || mul_i0_w !== 16'h0) begin
      bad++;
      $display("FAIL midrst_issue: got rdy=%0b i0=%h, required 1/0000", in_ready_w, mul_i0_w);
    end
    rst_n = 1'b1;
    clear_logs();
    repeat (4) push(16'h3, 16'h3);
    wait_res(1, 20);
    repeat (6) tick();
    total++;
    if (q_w.size() != 1 || q_w[0].sum !== 24'd36 || q_w[0].ovf !== 1'b0) begin
      bad++;
      $display("FAIL midrst_sum: got n=%0d sum=%0d, required 1 x 36", q_w.size(), (q_w.size() > 0) ? q_w[0].sum : 24'hx);
    end
  endtask

  initial begin
    test_reset();
    test_comb_path();
    test_basic();
    test_back_to_back();
    test_trunc_ovf();
    test_backpressure();
    test_gaps();
    test_reset_mid_group();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_custmul_mac_seq
